// File: rtl/dmem_stall_ctrl_if.sv
// Data-memory req/ack bus between the M-stage stall controller
// and a variable-latency data memory.
interface dmem_stall_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// M-stage sequencer for a req/ack data memory: freezes F..M, bubbles W.
// Optional access timeout with ERR state: define DMEM_TIMEOUT_EN.
module dmem_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic             MemToRegM,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      WriteDataM,
  dmem_stall_ctrl_if.master mem,
  output logic [31:0]      ReadDataM,
  output logic             StallM,
  output logic             FlushW,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             access;
  logic             req;

  assign access = MemWriteM | MemToRegM;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    StallM  = 1'b0;
    req     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (access) begin
          StallM  = 1'b1;
          state_d = REQ;
`ifdef DMEM_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      REQ: begin
        req    = 1'b1;
        StallM = 1'b1;
        if (mem.mem_ack) begin
          if (!MemWriteM) rdata_d = mem.mem_rdata;
          state_d = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
`endif
      end
      DONE: state_d = IDLE;
`ifdef DMEM_TIMEOUT_EN
      ERR: StallM = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    // Saturate rather than wrap so long runs stay meaningful
    stall_d = stall_q;
    if (StallM && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      stall_q <= '0;
`ifdef DMEM_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      stall_q <= stall_d;
`ifdef DMEM_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = MemWriteM;
  assign mem.mem_addr  = ALUOutM;
  assign mem.mem_wdata = WriteDataM;

  assign ReadDataM    = rdata_q;
  assign FlushW       = StallM;
  assign stall_cycles = stall_q;

`ifdef DMEM_TIMEOUT_EN
  assign mem_error = err_q;
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Scoreboard bench for dmem_stall_ctrl: random pipeline traffic against
// a memory responder with programmable ack latency.
module tb_dmem_stall_ctrl;
  localparam int CW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWriteM, MemToRegM;
  logic [31:0]   ALUOutM, WriteDataM;
  logic [31:0]   ReadDataM;
  logic          StallM, FlushW, mem_error;
  logic [CW-1:0] stall_cycles;

  dmem_stall_ctrl_if bus ();

  dmem_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .MemToRegM    (MemToRegM),
    .ALUOutM      (ALUOutM),
    .WriteDataM   (WriteDataM),
    .mem          (bus.master),
    .ReadDataM    (ReadDataM),
    .StallM       (StallM),
    .FlushW       (FlushW),
    .mem_error    (mem_error),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    int          len;
    int          total;
  } exp_t;

  typedef struct {
    int          k;
    logic [31:0] rd;
  } lat_t;

  exp_t exp_q[$];
  lat_t lat_q[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   stray_en = 1'b1;
  bit   stray_now = 1'b0;

  logic [31:0] model_rd = '0;
  int          model_total = 0;
  localparam int SAT = (1 << CW) - 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory responder: acks the k-th REQ cycle, strays acks when idle
  initial begin
    int reqcyc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        reqcyc++;
        if (lat_q.size() > 0 && reqcyc == lat_q[0].k) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = lat_q[0].rd;
          lat_q.pop_front();
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        reqcyc = 0;
        bus.mem_rdata = $urandom;
        bus.mem_ack = stray_now ||
                      (stray_en && ($urandom_range(0, 3) == 0));
        stray_now = 1'b0;
      end
    end
  end

  // Monitor: checks bus while requesting, pops a result at each completion
  initial begin
    int run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("flushw_eq_stall", {31'b0, FlushW}, {31'b0, StallM});
        if (bus.mem_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", {31'b0, bus.mem_req}, 32'd0);
          end else begin
            chk("mem_addr", bus.mem_addr, exp_q[0].addr);
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_q[0].we});
            chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
          end
        end
        if (StallM) begin
          run++;
        end else if (run > 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(run), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("read_data", ReadDataM, e.rd);
            chk("stall_len", 32'(run), 32'(e.len));
            chk("stall_cycles", 32'(stall_cycles), 32'(e.total));
            chk("mem_req_done", {31'b0, bus.mem_req}, 32'd0);
          end
          run = 0;
        end
      end
    end
  end

  // Drive one M-stage instruction and hold it until the pipeline advances
  task automatic issue(bit we, bit ld, logic [31:0] addr,
                       logic [31:0] wdata, int k, logic [31:0] rdata);
    exp_t e;
    lat_t l;
    bit   st;
    int   n;
    MemWriteM  = we;
    MemToRegM  = ld;
    ALUOutM    = addr;
    WriteDataM = wdata;
    if (we || ld) begin
      if (ld && !we) model_rd = rdata;
      model_total = model_total + k + 1;
      if (model_total > SAT) model_total = SAT;
      e.addr = addr; e.wdata = wdata; e.we = we;
      e.rd = model_rd; e.len = k + 1; e.total = model_total;
      exp_q.push_back(e);
      l.k = k; l.rd = rdata;
      lat_q.push_back(l);
    end
    n = 0;
    do begin
      @(negedge clk);
      st = StallM;
      @(posedge clk);
      #1;
      n++;
    end while (st && n < 200);
    if (st) chk("advance_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    MemWriteM = 1'b0; MemToRegM = 1'b0;
    ALUOutM = '0; WriteDataM = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_readdata", ReadDataM, 32'd0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_stallm", {31'b0, StallM}, 32'd0);
    chk("rst_flushw", {31'b0, FlushW}, 32'd0);
    chk("rst_mem_error", {31'b0, mem_error}, 32'd0);
    @(posedge clk);
    #1;

    mon_en = 1'b1;
    issue(1'b0, 1'b1, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h100, 32'h12345678, 4, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 32'h44, 32'h0, 1, 32'h11112222);
    issue(1'b0, 1'b1, 32'h48, 32'h0, 3, 32'h33334444);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b1, 32'h4C, 32'hA5A5A5A5, 2, 32'h55556666);
    issue(1'b0, 1'b1, 32'h50, 32'h0, TO, 32'h77778888);
    for (int i = 0; i < 40; i++) begin
      bit we, ld;
      we = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 1) == 0);
      issue(we, ld, $urandom, $urandom, $urandom_range(1, 6), $urandom);
    end
    MemWriteM = 1'b0; MemToRegM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_error_clear", {31'b0, mem_error}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Load with no ack: ERR after TO REQ cycles
    MemToRegM = 1'b1;
    ALUOutM = 32'h60;
    stray_en = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    chk("to_pre_req", {31'b0, bus.mem_req}, 32'd1);
    chk("to_pre_err", {31'b0, mem_error}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_err", {31'b0, mem_error}, 32'd1);
    chk("to_req", {31'b0, bus.mem_req}, 32'd0);
    chk("to_stall", {31'b0, StallM}, 32'd1);
    MemToRegM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_sticky", {31'b0, mem_error}, 32'd1);
    chk("to_stall_held", {31'b0, StallM}, 32'd1);
    chk("to_flush_held", {31'b0, FlushW}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("to_reset_err", {31'b0, mem_error}, 32'd0);
    stray_en = 1'b1;
`endif

    // Reset arriving in the 2nd REQ cycle of a load
    MemToRegM = 1'b1;
    ALUOutM = 32'h80;
    @(posedge clk);
    #1;
    chk("rq_req1", {31'b0, bus.mem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk("rq_req2", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b1;
    MemToRegM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rq_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rq_stallm", {31'b0, StallM}, 32'd0);
    chk("rq_readdata", ReadDataM, 32'd0);
    chk("rq_stall_cycles", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    stray_now = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_readdata", ReadDataM, 32'd0);
    chk("stray_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("stray_stall_cycles", 32'(stall_cycles), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Sequences the memory stage of the 5-stage MIPS pipeline against a variable-latency data memory that uses a req/ack handshake.
- Sits between the E-to-M pipeline register outputs (ALUOutM, WriteDataM, MemWriteM, MemToRegM) and the data memory.
- Freezes F/D/E/M while an access is outstanding, and injects bubbles into W.
- Returns captured load data and counts stall cycles.

Parameters:
- TIMEOUT, 16, number of REQ cycles without mem_ack before the access is declared failed (used only with DMEM_TIMEOUT_EN).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- MemWriteM  input  1  M-stage instruction is a store
- MemToRegM  input  1  M-stage instruction is a load
- ALUOutM  input  32  M-stage byte address
- WriteDataM  input  32  M-stage store data
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  32  request address
- mem_wdata  output  32  request write data
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse from memory
- ReadDataM  output  32  registered load data for the M-to-W register
- StallM  output  1  freeze PC and the F/D, D/E and E/M registers
- FlushW  output  1  clear the M-to-W register (bubble)
- mem_error  output  1  sticky access failure flag
- stall_cycles  output  CNT_W  saturating count of cycles with StallM=1

Behaviour:
- States: IDLE, REQ, DONE, ERR (ERR is reachable only with DMEM_TIMEOUT_EN).
- Reset (synchronous, checked before everything else): state to IDLE; ReadDataM, stall_cycles, mem_error and the timeout counter to 0. mem_req, StallM and FlushW are then 0 by decode.
- A reset arriving in REQ drops the request the next cycle with no handshake completion. A later stray mem_ack is ignored.
- access = MemWriteM | MemToRegM.
- If both MemWriteM and MemToRegM are 1, treat the access as a write (mem_we=1). ReadDataM is not updated.
- IDLE:
  - access=0: StallM=0, mem_req=0.
  - access=1: StallM=1 combinationally in the same cycle; next state REQ. mem_req stays 0 this cycle.
- REQ:
  - Outputs: mem_req=1; StallM=1; mem_addr=ALUOutM; mem_wdata=WriteDataM; mem_we=MemWriteM. These are stable because M is frozen.
  - mem_ack=1 sampled at the edge: if read, ReadDataM <= mem_rdata; next state DONE.
- DONE:
  - StallM=0 and mem_req=0, so the pipeline advances at this edge.
  - ReadDataM holds the captured value.
  - Next state is IDLE unconditionally, even if the following instruction is also an access.
- FlushW = StallM in every state.
- mem_ack is ignored outside REQ.
- mem_addr and mem_wdata track the inputs at all times; only mem_req qualifies them.
- Latency: if ack arrives in the k-th REQ cycle (k≥1), StallM is high for k+1 cycles. The instruction leaves M at the DONE edge, k+2 cycles after entering.
- Minimum memory-op occupancy of M is 3 cycles; back-to-back accesses each cost 3 or more.
- ReadDataM changes only on a read ack and is otherwise held. It is not cleared by DONE.
- stall_cycles increments by 1 on every edge where StallM=1 and saturates at all-ones (no wrap).
- mem_error is 0 unless set through DMEM_TIMEOUT_EN.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - An up-counter clears on entry to REQ and increments each REQ cycle without ack.
  - If it reaches TIMEOUT with no ack, the next state is ERR.
  - ERR: mem_req=0, StallM=1 and FlushW=1 permanently, mem_error=1 sticky. Only reset exits ERR.
  - An ack in the same cycle the counter reaches TIMEOUT wins: the state goes to DONE.
- Without the macro: REQ waits indefinitely, ERR does not exist, and mem_error is tied 0.

Test Plan:
1. Reset mid-REQ: load issued, reset asserted in 2nd REQ cycle → next cycle mem_req=0, StallM=0, ReadDataM=0, stall_cycles=0; mem_ack 2 cycles later has no effect.
2. Load, ack in first REQ cycle, mem_rdata=0xDEADBEEF, ALUOutM=0x40 → mem_addr=0x40, mem_we=0, StallM high exactly 2 cycles, ReadDataM=0xDEADBEEF in DONE, stall_cycles=2.
3. Store ALUOutM=0x100, WriteDataM=0x12345678, ack after 4 REQ cycles → mem_we=1, mem_wdata=0x12345678 throughout, StallM high 5 cycles, ReadDataM unchanged, FlushW identical to StallM.
4. Back-to-back load/load, acks k=1 then k=3 → IDLE→REQ→DONE→IDLE→REQ×3→DONE, ReadDataM updates twice, stall_cycles=6.
5. Stray mem_ack pulses in IDLE and DONE, no access → no state change, mem_req=0, ReadDataM held.
6. (DMEM_TIMEOUT_EN, TIMEOUT=16) load with no ack → ERR after 16 REQ cycles, mem_error=1, StallM=1 persists; ack exactly on cycle 16 → DONE, mem_error=0.
